// File: rtl/sha256_pkg.sv
// ============================================================================
//  sha256_pkg
//  Shared constants, chunk selects and response FSM encoding for the
//  SHA-256 header server.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
  localparam logic [31:0] LEN_HDR    = 32'd640;
  localparam logic [31:0] LEN_DIGEST = 32'd256;

  localparam logic [1:0] CHUNK_HDR0 = 2'd0;
  localparam logic [1:0] CHUNK_HDR1 = 2'd1;
  localparam logic [1:0] CHUNK_DIG  = 2'd2;

  localparam int HDR_WORDS = 19;
  localparam int DIG_WORDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } resp_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha256_word_mux.sv
// ============================================================================
//  sha256_word_mux
//  Combinational map from (chunk_sel, addr) and storage to a message word,
//  including SHA-256 padding/length words and the optional nonce byte swap.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sha256_word_mux
  import sha256_pkg::*;
#(
  parameter bit NONCE_BSWAP = 1'b1
) (
  input  logic [1:0]  chunk_sel,
  input  logic [3:0]  addr,
  input  logic [31:0] hdr [HDR_WORDS],
  input  logic [31:0] nonce,
  input  logic [31:0] dig [DIG_WORDS],
  output logic [31:0] word
);

  logic [31:0] w_nonce_word;

  generate
    if (NONCE_BSWAP) begin : g_bswap
      assign w_nonce_word = bswap32(nonce);
    end else begin : g_no_bswap
      assign w_nonce_word = nonce;
    end
  endgenerate

  always_comb begin
    word = '0;
    case (chunk_sel)
      CHUNK_HDR0: word = hdr[addr];
      CHUNK_HDR1: begin
        case (addr)
          4'd0:    word = hdr[16];
          4'd1:    word = hdr[17];
          4'd2:    word = hdr[18];
          4'd3:    word = w_nonce_word;
          4'd4:    word = PAD_WORD;
          4'd15:   word = LEN_HDR;
          default: word = '0;
        endcase
      end
      CHUNK_DIG: begin
        if (!addr[3])          word = dig[addr[2:0]];
        else if (addr == 4'd8) word = PAD_WORD;
        else if (addr == 4'd15) word = LEN_DIGEST;
        else                   word = '0;
      end
      default: word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sha256_hdr_server.sv
// ============================================================================
//  sha256_hdr_server
//  Word responder for the SHA-256 core: holds header, nonce and first-pass
//  digest, and serves one registered word per request handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sha256_hdr_server
  import sha256_pkg::*;
#(
  parameter bit NONCE_BSWAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         nonce_load,
  input  logic [31:0]  nonce_in,
  input  logic         nonce_inc,
  output logic [31:0]  nonce,
  input  logic         digest_load,
  input  logic [255:0] digest_in,
  input  logic [1:0]   chunk_sel,
  input  logic         rq,
  input  logic [3:0]   addr,
  output logic [31:0]  data,
  output logic         rdy,
  output logic         chunk_done
);

  logic [31:0] r_hdr [HDR_WORDS];
  logic [31:0] r_dig [DIG_WORDS];
  logic [31:0] r_nonce;
  logic [31:0] r_data;
  logic        r_rdy;
  logic        r_chunk_done;

  resp_state_t r_state;
  resp_state_t w_state_nxt;
  logic        w_capture;
  logic [31:0] w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HDR_WORDS; i++) r_hdr[i] <= '0;
    end else if (wr_en && (wr_addr < 5'(HDR_WORDS))) begin
      r_hdr[wr_addr] <= wr_data;
    end
  end

  // Word 0 of the digest sits in the top 32 bits of digest_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIG_WORDS; i++) r_dig[i] <= '0;
    end else if (digest_load) begin
      for (int i = 0; i < DIG_WORDS; i++)
        r_dig[i] <= digest_in[(DIG_WORDS-1-i)*32 +: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_nonce <= '0;
    else if (nonce_load) r_nonce <= nonce_in;
    else if (nonce_inc)  r_nonce <= r_nonce + 32'd1;
  end

  sha256_word_mux #(
    .NONCE_BSWAP (NONCE_BSWAP)
  ) u_word_mux (
    .chunk_sel (chunk_sel),
    .addr      (addr),
    .hdr       (r_hdr),
    .nonce     (r_nonce),
    .dig       (r_dig),
    .word      (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rq) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = rq ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!rq) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word is frozen at capture; storage writes in the same cycle land next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_rdy        <= 1'b0;
      r_chunk_done <= 1'b0;
    end else begin
      r_rdy        <= w_capture;
      r_chunk_done <= w_capture && (addr == 4'd15);
      if (w_capture) r_data <= w_word;
    end
  end

  assign nonce      = r_nonce;
  assign data       = r_data;
  assign rdy        = r_rdy;
  assign chunk_done = r_chunk_done;

endmodule

`default_nettype wire

// File: tb/tb_sha256_hdr_server.sv
// ============================================================================
//  tb_sha256_hdr_server
//  Self-checking bench: emulates the SHA core handshake, scoreboards served
//  words against a reference model of header/nonce/digest storage.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sha256_hdr_server;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         nonce_load;
  logic [31:0]  nonce_in;
  logic         nonce_inc;
  logic [31:0]  nonce;
  logic         digest_load;
  logic [255:0] digest_in;
  logic [1:0]   chunk_sel;
  logic         rq;
  logic [3:0]   addr;
  logic [31:0]  data;
  logic         rdy;
  logic         chunk_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_rdy_cyc = 0;

  logic [31:0] m_hdr [19];
  logic [31:0] m_dig [8];
  logic [31:0] m_nonce;

  logic [31:0] exp_q [$];
  logic [31:0] exp_done_q [$];

  sha256_hdr_server #(
    .NONCE_BSWAP (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .nonce_load  (nonce_load),
    .nonce_in    (nonce_in),
    .nonce_inc   (nonce_inc),
    .nonce       (nonce),
    .digest_load (digest_load),
    .digest_in   (digest_in),
    .chunk_sel   (chunk_sel),
    .rq          (rq),
    .addr        (addr),
    .data        (data),
    .rdy         (rdy),
    .chunk_done  (chunk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [1:0] sel, input logic [3:0] a);
    logic [31:0] w;
    w = 32'h0;
    case (sel)
      2'd0: w = m_hdr[a];
      2'd1: begin
        if (a <= 4'd2)      w = m_hdr[16 + int'(a)];
        else if (a == 4'd3) w = {m_nonce[7:0], m_nonce[15:8], m_nonce[23:16], m_nonce[31:24]};
        else if (a == 4'd4) w = 32'h8000_0000;
        else if (a == 4'd15) w = 32'h0000_0280;
      end
      2'd2: begin
        if (a <= 4'd7)      w = m_dig[a];
        else if (a == 4'd8) w = 32'h8000_0000;
        else if (a == 4'd15) w = 32'h0000_0100;
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 19; i++) m_hdr[i] = 32'h0;
    for (int i = 0; i < 8; i++)  m_dig[i] = 32'h0;
    m_nonce = 32'h0;
  endtask

  // Wait for rdy after the expected entry is queued, then pop and compare.
  task automatic wait_resp();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (rdy) got = 1'b1;
    end
    if (!got) begin
      check("rdy_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      void'(exp_done_q.pop_front());
    end else begin
      last_rdy_cyc = cyc;
      check("word", data, exp_q.pop_front());
      check("chunk_done", {31'd0, chunk_done}, exp_done_q.pop_front());
    end
  endtask

  // Core-style handshake: rq held through the rdy-seeing edge, re-raised one cycle later.
  task automatic serve(input logic [1:0] sel, input logic [3:0] a);
    chunk_sel = sel;
    addr      = a;
    rq        = 1'b1;
    exp_q.push_back(exp_word(sel, a));
    exp_done_q.push_back({31'd0, a == 4'd15});
    wait_resp();
    @(negedge clk);
    check("rdy_pulse", {31'd0, rdy}, 32'd0);
    rq = 1'b0;
    @(negedge clk);
  endtask

  task automatic hdr_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 5'd19) m_hdr[a] = d;
  endtask

  task automatic load_nonce(input logic [31:0] v, input logic inc);
    nonce_load = 1'b1; nonce_in = v; nonce_inc = inc;
    @(negedge clk);
    nonce_load = 1'b0; nonce_inc = 1'b0;
    m_nonce = v;
  endtask

  initial begin
    int first_cyc;
    int cnt;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    nonce_load = 1'b0; nonce_in = '0; nonce_inc = 1'b0;
    digest_load = 1'b0; digest_in = '0; chunk_sel = '0; rq = 1'b0; addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'd0, rdy}, 32'd0);
    check("rst_done", {31'd0, chunk_done}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_nonce", nonce, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    serve(2'd0, 4'd0);

    for (int n = 0; n < 19; n++) hdr_write(5'(n), 32'h0100_0000 + n);
    hdr_write(5'd19, 32'hDEAD_BEEF);
    hdr_write(5'd31, 32'hBAAD_F00D);

    first_cyc = 0;
    for (int a = 0; a < 16; a++) begin
      serve(2'd0, 4'(a));
      if (a == 0) first_cyc = last_rdy_cyc;
    end
    check("chunk0_span", 32'(last_rdy_cyc - first_cyc + 3), 32'd48);

    load_nonce(32'h1234_5678, 1'b0);
    check("nonce_load", nonce, 32'h1234_5678);
    for (int a = 0; a < 16; a++) serve(2'd1, 4'(a));

    load_nonce(32'hFFFF_FFFF, 1'b0);
    nonce_inc = 1'b1;
    @(negedge clk);
    nonce_inc = 1'b0;
    m_nonce = m_nonce + 32'd1;
    check("nonce_wrap", nonce, 32'h0);
    load_nonce(32'd5, 1'b1);
    check("nonce_prio", nonce, 32'd5);

    for (int i = 0; i < 8; i++) begin
      digest_in[(7-i)*32 +: 32] = 32'h0000_00A0 + i;
      m_dig[i] = 32'h0000_00A0 + i;
    end
    digest_load = 1'b1;
    @(negedge clk);
    digest_load = 1'b0;
    for (int a = 0; a < 16; a++) serve(2'd2, 4'(a));

    serve(2'd1, 4'd3);
    serve(2'd3, 4'd0);
    serve(2'd3, 4'd7);
    serve(2'd3, 4'd15);

    // Write coinciding with capture: old word served, new one next time.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFE_0000;
    chunk_sel = 2'd0; addr = 4'd0; rq = 1'b1;
    exp_q.push_back(exp_word(2'd0, 4'd0));
    exp_done_q.push_back(32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    m_hdr[0] = 32'hCAFE_0000;
    check("coincide_rdy", {31'd0, rdy}, 32'd1);
    check("coincide_word", data, exp_q.pop_front());
    void'(exp_done_q.pop_front());
    @(negedge clk);
    rq = 1'b0;
    @(negedge clk);
    serve(2'd0, 4'd0);

    chunk_sel = 2'd0; addr = 4'd1; rq = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    rq = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    check("hold_rdy_count", 32'(cnt), 32'd1);

    chunk_sel = 2'd0; addr = 4'd15; rq = 1'b1;
    @(negedge clk);
    check("pre_rst_rdy", {31'd0, rdy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_rdy", {31'd0, rdy}, 32'd0);
    check("midrst_done", {31'd0, chunk_done}, 32'd0);
    check("midrst_data", data, 32'd0);
    rq = 1'b0;
    @(negedge clk);
    check("midrst_nonce", nonce, 32'd0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    serve(2'd0, 4'd15);
    serve(2'd1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
